// File: rtl/lbp_host_mem.sv
// Host-side image memory and LBP result memory for the LBP engine.
// Define LBP_HOST_CHECK_EN to build the written-bitmap protocol checker driving err.
module lbp_host_mem #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  output logic [AW:0]   wr_count,
  output logic          done,
  input  logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_data,
  output logic          err
);

  localparam int          NPIX      = IMG_W * IMG_H;
  localparam logic [AW:0] NPIX_W    = (AW+1)'(NPIX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW:0] CNT_MAX   = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ld_ready_q, ld_ready_d;
  logic          gray_ready_q, gray_ready_d;
  logic          done_q, done_d;
  logic [AW:0]   wr_count_q, wr_count_d;
  logic [DW-1:0] res_data_q, res_data_d;

  logic [DW-1:0] img_mem [NPIX];
  logic [DW-1:0] res_mem [NPIX];

  logic ld_we_s, lbp_we_s, lbp_in_range_s, gray_in_range_s, res_in_range_s;

  // Write strobes and address range qualifiers.
  always_comb begin
    ld_we_s         = (state_q == ST_LOAD) && ld_valid && ld_ready_q;
    lbp_we_s        = (state_q == ST_SERVE) && lbp_valid;
    lbp_in_range_s  = ({1'b0, lbp_addr} < NPIX_W);
    gray_in_range_s = ({1'b0, gray_addr} < NPIX_W);
    res_in_range_s  = ({1'b0, res_addr} < NPIX_W);
  end

  // Next-state and output computation for the load/serve/done sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_count_d = wr_count_q;
    done_d     = done_q;
    res_data_d = {DW{1'b0}};
    case (state_q)
      ST_LOAD: begin
        if (ld_we_s) begin
          ptr_d = ptr_q + AW'(1);
          if (ptr_q == LAST_ADDR) begin
            state_d = ST_SERVE;
            ptr_d   = {AW{1'b0}};
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_SERVE: begin
        if (lbp_we_s && (wr_count_q != CNT_MAX)) begin
          wr_count_d = wr_count_q + (AW+1)'(1);
        end else begin
          wr_count_d = wr_count_q;
        end
        // A write coinciding with finish is still committed above.
        if (finish) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_DONE: begin
        if (res_in_range_s) begin
          res_data_d = res_mem[res_addr];
        end else begin
          res_data_d = {DW{1'b0}};
        end
      end
      default: begin
        state_d = ST_LOAD;
        ptr_d   = {AW{1'b0}};
      end
    endcase
    ld_ready_d   = (state_d == ST_LOAD);
    gray_ready_d = (state_d != ST_LOAD);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      ptr_q        <= {AW{1'b0}};
      ld_ready_q   <= 1'b0;
      gray_ready_q <= 1'b0;
      done_q       <= 1'b0;
      wr_count_q   <= {(AW+1){1'b0}};
      res_data_q   <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ld_ready_q   <= ld_ready_d;
      gray_ready_q <= gray_ready_d;
      done_q       <= done_d;
      wr_count_q   <= wr_count_d;
      res_data_q   <= res_data_d;
    end
  end

  // Image and result storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_we_s) begin
      img_mem[ptr_q] <= ld_data;
    end
    if (lbp_we_s && lbp_in_range_s) begin
      res_mem[lbp_addr] <= lbp_data;
    end
  end

  // Zero-latency read so the engine samples pixel data at the same edge.
  always_comb begin
    if (gray_req && (state_q != ST_LOAD) && gray_in_range_s) begin
      gray_data = img_mem[gray_addr];
    end else begin
      gray_data = {DW{1'b0}};
    end
  end

  assign ld_ready   = ld_ready_q;
  assign gray_ready = gray_ready_q;
  assign done       = done_q;
  assign wr_count   = wr_count_q;
  assign res_data   = res_data_q;

`ifdef LBP_HOST_CHECK_EN
  localparam logic [AW:0] INTERIOR = (AW+1)'((IMG_W - 2) * (IMG_H - 2));

  logic [NPIX-1:0] written_q, written_d;
  logic            err_q, err_d;
  logic [AW-1:0]   row_s, col_s;
  logic            border_s;

  // Protocol checks: border writes, rewrites, traffic during load, short finish.
  always_comb begin
    row_s     = lbp_addr / AW'(IMG_W);
    col_s     = lbp_addr % AW'(IMG_W);
    border_s  = (row_s == {AW{1'b0}}) || (row_s == AW'(IMG_H - 1)) ||
                (col_s == {AW{1'b0}}) || (col_s == AW'(IMG_W - 1));
    written_d = written_q;
    err_d     = err_q;
    if (lbp_we_s && lbp_in_range_s) begin
      written_d[lbp_addr] = 1'b1;
      if (border_s || written_q[lbp_addr]) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      written_d = written_q;
    end
    if ((state_q == ST_LOAD) && (lbp_valid || gray_req)) begin
      err_d = 1'b1;
    end else if ((state_q == ST_SERVE) && finish && (wr_count_d != INTERIOR)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // Bitmap and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      written_q <= {NPIX{1'b0}};
      err_q     <= 1'b0;
    end else begin
      written_q <= written_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_host_mem.sv
// Self-checking bench for lbp_host_mem: load, gray reads, result writes, readout, reset.
module tb_lbp_host_mem;
  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int NPIX = 16384;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic [AW:0]   wr_count;
  logic          done;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic          err;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  always #5 clk = ~clk;

  lbp_host_mem dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .wr_count(wr_count), .done(done),
    .res_addr(res_addr), .res_data(res_data), .err(err)
  );

  function automatic logic [DW-1:0] pix(input int a, input int mult, input int off);
    return 8'((a * mult + off) % 256);
  endfunction

  function automatic logic [DW-1:0] wdat(input int a);
    if (a == 129) return 8'hA5;
    else if (a == 130) return 8'h3C;
    else return 8'((a ^ (a >> 8)) & 255);
  endfunction

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_data = 8'h00; gray_req = 1'b0; gray_addr = 14'd0;
    lbp_valid = 1'b0; lbp_addr = 14'd0; lbp_data = 8'h00; finish = 1'b0; res_addr = 14'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ld_ready !== 1'b0)   begin errors++; $display("FAIL rst_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (gray_ready !== 1'b0) begin errors++; $display("FAIL rst_gray_ready got=%b exp=0", gray_ready); end
    checks++; if (wr_count !== 15'd0)  begin errors++; $display("FAIL rst_wr_count got=%0d exp=0", wr_count); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (res_data !== 8'h00)  begin errors++; $display("FAIL rst_res_data got=%h exp=00", res_data); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
    reset = 1'b1;
    #1;
    checks++; if (ld_ready !== 1'b0)   begin errors++; $display("FAIL rst_release_ld_ready got=%b exp=0", ld_ready); end
  endtask

  task automatic load_image(input bit toggle, input int mult, input int off);
    int n;
    int cyc;
    bit acc;
    n = 0;
    cyc = 0;
    while (n < NPIX && cyc < 3 * NPIX) begin
      ld_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      ld_data  = pix(n, mult, off);
      acc      = ld_valid && ld_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        n++;
        if (n == NPIX - 1) begin
          checks++; if (gray_ready !== 1'b0) begin errors++; $display("FAIL load_gray_ready_early got=%b exp=0", gray_ready); end
          checks++; if (ld_ready !== 1'b1)   begin errors++; $display("FAIL load_ld_ready_mid got=%b exp=1", ld_ready); end
        end else if (n == NPIX) begin
          checks++; if (gray_ready !== 1'b1) begin errors++; $display("FAIL load_gray_ready got=%b exp=1", gray_ready); end
          checks++; if (ld_ready !== 1'b0)   begin errors++; $display("FAIL load_ld_ready_end got=%b exp=0", ld_ready); end
        end
      end
    end
    ld_valid = 1'b0;
    if (n != NPIX) begin
      checks++; errors++;
      $display("FAIL load_timeout accepted=%0d exp=%0d", n, NPIX);
    end
  endtask

  task automatic gray_read(input int a, input logic [DW-1:0] e);
    gray_req  = 1'b1;
    gray_addr = AW'(a);
    exp_q.push_back(e);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (gray_data !== exp_v) begin errors++; $display("FAIL gray_read addr=%0d got=%h exp=%h", a, gray_data, exp_v); end
    gray_req = 1'b0;
  endtask

  task automatic test_load_hold();
    load_image(1'b0, 1, 0);
    gray_read(300, 8'd44);
    gray_read(16383, 8'd255);
  endtask

  task automatic test_gray_zero();
    gray_req = 1'b0; gray_addr = 14'd300;
    #1;
    checks++; if (gray_data !== 8'h00) begin errors++; $display("FAIL gray_req_low got=%h exp=00", gray_data); end
    ld_valid = 1'b1; ld_data = 8'hFF;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL serve_ld_ready got=%b exp=0", ld_ready); end
    gray_read(300, 8'd44);
    gray_read(0, 8'd0);
  endtask

  task automatic test_load_toggle();
    test_reset();
    checks++; if (gray_ready !== 1'b0) begin errors++; $display("FAIL reload_gray_ready got=%b exp=0", gray_ready); end
    load_image(1'b1, 7, 3);
    gray_read(0, pix(0, 7, 3));
    gray_read(1, pix(1, 7, 3));
    gray_read(300, pix(300, 7, 3));
    gray_read(16383, pix(16383, 7, 3));
  endtask

  task automatic test_writes();
    int a;
    for (int r = 1; r < 127; r++) begin
      for (int c = 1; c < 127; c++) begin
        a = r * 128 + c;
        lbp_valid = 1'b1; lbp_addr = AW'(a); lbp_data = wdat(a); finish = (a == 16254);
        @(posedge clk); #1;
        if (a == 130) begin
          checks++; if (wr_count !== 15'd2) begin errors++; $display("FAIL wr_count_two got=%0d exp=2", wr_count); end
          checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL serve_res_data got=%h exp=00", res_data); end
          checks++; if (done !== 1'b0)      begin errors++; $display("FAIL serve_done got=%b exp=0", done); end
        end
      end
    end
    lbp_valid = 1'b0; finish = 1'b0;
    checks++; if (wr_count !== 15'd15876) begin errors++; $display("FAIL wr_count_final got=%0d exp=15876", wr_count); end
    checks++; if (done !== 1'b1)          begin errors++; $display("FAIL done_final got=%b exp=1", done); end
    checks++; if (err !== 1'b0)           begin errors++; $display("FAIL err_final got=%b exp=0", err); end
    checks++; if (gray_ready !== 1'b1)    begin errors++; $display("FAIL done_gray_ready got=%b exp=1", gray_ready); end
  endtask

  task automatic test_readout();
    int addrs[5];
    addrs = '{129, 130, 16254, 5000, 1000};
    for (int i = 0; i < 5; i++) begin
      res_addr = AW'(addrs[i]);
      exp_q.push_back(wdat(addrs[i]));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (res_data !== exp_v) begin errors++; $display("FAIL readout addr=%0d got=%h exp=%h", addrs[i], res_data, exp_v); end
    end
    lbp_valid = 1'b1; lbp_addr = 14'd129; lbp_data = 8'h00;
    @(posedge clk); #1;
    lbp_valid = 1'b0;
    checks++; if (wr_count !== 15'd15876) begin errors++; $display("FAIL done_write_count got=%0d exp=15876", wr_count); end
    res_addr = 14'd129;
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++; if (res_data !== exp_v) begin errors++; $display("FAIL done_write_ignored got=%h exp=%h", res_data, exp_v); end
  endtask

  task automatic test_err_reset();
`ifdef LBP_HOST_CHECK_EN
    test_reset();
    load_image(1'b0, 1, 0);
    lbp_valid = 1'b1; lbp_addr = 14'd0; lbp_data = 8'h11;
    @(posedge clk); #1;
    lbp_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_border got=%b exp=1", err); end
    for (int i = 0; i < 2; i++) begin
      lbp_valid = 1'b1; lbp_addr = 14'd200; lbp_data = 8'h22;
      @(posedge clk); #1;
    end
    lbp_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    checks++; if (wr_count !== 15'd3) begin errors++; $display("FAIL err_wr_count got=%0d exp=3", wr_count); end
`endif
    checks++; if (gray_ready !== 1'b1) begin errors++; $display("FAIL pre_pulse_gray_ready got=%b exp=1", gray_ready); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (gray_ready !== 1'b0) begin errors++; $display("FAIL async_gray_ready got=%b exp=0", gray_ready); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL async_err got=%b exp=0", err); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL async_done got=%b exp=0", done); end
    checks++; if (wr_count !== 15'd0)  begin errors++; $display("FAIL async_wr_count got=%0d exp=0", wr_count); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (ld_ready !== 1'b1)   begin errors++; $display("FAIL post_reset_ld_ready got=%b exp=1", ld_ready); end
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_gray_zero();
    test_load_toggle();
    test_writes();
    test_readout();
    test_err_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
